// File: rtl/id_stage_if.sv
// id_stage_if: fetch/decode/execute/writeback signal bundle for id_stage.
//   slave  modport: the decode stage (id_stage) side.
//   master modport: the driving environment (fetch, execute, writeback).
//   if_valid/if_instr/if_ready : fetch handshake, instr = op|rd|ra|rb|imm3
//   flush                      : kill the instruction held for execute
//   rd_a_sel/rd_b_sel          : register-file read selects
//   ex_valid/ex_ready/ex_*     : decoded instruction handed to execute
//   wb_ld_valid/wb_ld_sel      : load writeback completion
interface id_stage_if;
    logic        if_valid;
    logic [15:0] if_instr;
    logic        if_ready;
    logic        flush;
    logic [2:0]  rd_a_sel;
    logic [2:0]  rd_b_sel;
    logic        ex_valid;
    logic        ex_ready;
    logic [3:0]  ex_op;
    logic [2:0]  ex_wr_sel;
    logic        ex_wr_en;
    logic [2:0]  ex_imm;
    logic        wb_ld_valid;
    logic [2:0]  wb_ld_sel;

    modport slave (
        input  if_valid, if_instr, flush, ex_ready, wb_ld_valid, wb_ld_sel,
        output if_ready, rd_a_sel, rd_b_sel, ex_valid, ex_op, ex_wr_sel, ex_wr_en, ex_imm
    );

    modport master (
        output if_valid, if_instr, flush, ex_ready, wb_ld_valid, wb_ld_sel,
        input  if_ready, rd_a_sel, rd_b_sel, ex_valid, ex_op, ex_wr_sel, ex_wr_en, ex_imm
    );
endinterface

// File: rtl/id_stage.sv
// id_stage: instruction decode stage with held register-file selects and optional load-use scoreboard.
//   clk   : single clock, all state on rising edge
//   rst_n : asynchronous active-low reset
//   bus   : id_stage_if.slave (fetch handshake, flush, read selects, execute outputs, load writeback)
//   Macro ID_SCOREBOARD_EN enables the 8-bit pending-load mask and hazard stall;
//   without it load-use spacing is left to the compiler and writeback inputs are ignored.
module id_stage #(
    parameter logic [3:0] LOAD_OP = 4'hA,
    parameter logic [3:0] NOP_OP  = 4'hF
) (
    input  logic      clk,
    input  logic      rst_n,
    id_stage_if.slave bus
);
    logic [3:0] op;
    logic [2:0] rd, ra, rb, imm;
    logic       hazard, if_ready, accept;
    logic       ex_valid_q, ex_valid_d, ex_wr_en_q, ex_wr_en_d;
    logic [3:0] ex_op_q, ex_op_d;
    logic [2:0] ex_wr_sel_q, ex_wr_sel_d, ex_imm_q, ex_imm_d, ra_q, ra_d, rb_q, rb_d;

    assign {op, rd, ra, rb, imm} = bus.if_instr;
    assign if_ready = !bus.flush && !hazard && (!ex_valid_q || bus.ex_ready);
    assign accept   = bus.if_valid && if_ready;

    // Selects follow the offered instruction only while it can be taken; otherwise
    // they hold the last accepted sources so the registered read data stays stable.
    assign bus.if_ready  = if_ready;
    assign bus.rd_a_sel  = if_ready ? ra : ra_q;
    assign bus.rd_b_sel  = if_ready ? rb : rb_q;
    assign bus.ex_valid  = ex_valid_q;
    assign bus.ex_op     = ex_op_q;
    assign bus.ex_wr_sel = ex_wr_sel_q;
    assign bus.ex_wr_en  = ex_wr_en_q;
    assign bus.ex_imm    = ex_imm_q;

    always_comb begin
        ex_valid_d  = bus.flush ? 1'b0 : accept ? 1'b1 : ex_valid_q && !bus.ex_ready;
        ex_op_d     = accept ? op : ex_op_q;
        ex_wr_sel_d = accept ? rd : ex_wr_sel_q;
        ex_wr_en_d  = accept ? (op != NOP_OP) : ex_wr_en_q;
        ex_imm_d    = accept ? imm : ex_imm_q;
        ra_d        = accept ? ra : ra_q;
        rb_d        = accept ? rb : rb_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q  <= 1'b0;
            ex_op_q     <= NOP_OP;
            ex_wr_sel_q <= 3'd0;
            ex_wr_en_q  <= 1'b0;
            ex_imm_q    <= 3'd0;
            ra_q        <= 3'd0;
            rb_q        <= 3'd0;
        end else begin
            ex_valid_q  <= ex_valid_d;
            ex_op_q     <= ex_op_d;
            ex_wr_sel_q <= ex_wr_sel_d;
            ex_wr_en_q  <= ex_wr_en_d;
            ex_imm_q    <= ex_imm_d;
            ra_q        <= ra_d;
            rb_q        <= rb_d;
        end
    end

`ifdef ID_SCOREBOARD_EN
    logic [7:0] pend_q, pend_d;

    // Set is OR-ed in after the clear so a new load to the same register wins.
    // Flush does not touch the mask: loads already issued still write back.
    assign pend_d = (pend_q & ~(bus.wb_ld_valid ? (8'd1 << bus.wb_ld_sel) : 8'd0))
                  | ((accept && op == LOAD_OP) ? (8'd1 << rd) : 8'd0);
    // Uses the registered mask, so a bit clearing this cycle still stalls.
    assign hazard = bus.if_valid && (pend_q[ra] || pend_q[rb] || pend_q[rd]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pend_q <= 8'd0;
        else        pend_q <= pend_d;
    end
`else
    logic unused_wb;

    assign hazard    = 1'b0;
    assign unused_wb = ^{bus.wb_ld_valid, bus.wb_ld_sel};
`endif
endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: scoreboard-based bench for id_stage.
module tb_id_stage;
    logic clk = 1'b0;
    logic rst_n;
    int checks = 0;
    int failures = 0;
    logic [10:0] sb[$];
    logic [10:0] e;

    id_stage_if bus();
    id_stage dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required finish");
        $fatal(1, "timeout");
    end

    function automatic logic [15:0] mk(input logic [3:0] op, input logic [2:0] rd,
                                       input logic [2:0] ra, input logic [2:0] rb, input logic [2:0] imm);
        return {op, rd, ra, rb, imm};
    endfunction

    function automatic logic [10:0] ex(input logic [15:0] ins);
        return {ins[15:12], ins[11:9], ins[2:0], ins[15:12] != 4'hF};
    endfunction

    function automatic logic [11:0] got();
        return {bus.ex_valid, bus.ex_op, bus.ex_wr_sel, bus.ex_imm, bus.ex_wr_en};
    endfunction

    task automatic drv(input logic v, input logic [15:0] ins, input logic er,
                       input logic fl, input logic wv, input logic [2:0] ws);
        bus.if_valid = v; bus.if_instr = ins; bus.ex_ready = er;
        bus.flush = fl; bus.wb_ld_valid = wv; bus.wb_ld_sel = ws;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        drv(1, mk(4'h1, 3'd1, 3'd3, 3'd4, 3'd0), 1, 1, 0, 0);
        @(negedge clk); #1;
        checks++;
        if (got() !== {1'b0, 4'hF, 3'd0, 3'd0, 1'b0}) begin
            failures++; $display("FAIL reset_ex got=%h exp=%h", got(), {1'b0, 4'hF, 3'd0, 3'd0, 1'b0});
        end
        checks++;
        if ({bus.if_ready, bus.rd_a_sel, bus.rd_b_sel} !== 7'd0) begin
            failures++; $display("FAIL reset_sel got=%h exp=0", {bus.if_ready, bus.rd_a_sel, bus.rd_b_sel});
        end
    endtask

    task automatic test_alu_stream;
        logic [15:0] ins [4];
        ins[0] = mk(4'h1, 3'd1, 3'd2, 3'd3, 3'd4);
        ins[1] = mk(4'h5, 3'd6, 3'd7, 3'd0, 3'd1);
        ins[2] = mk(4'hF, 3'd3, 3'd4, 3'd5, 3'd6);
        ins[3] = mk(4'h7, 3'd7, 3'd1, 3'd6, 3'd7);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 0) rst_n = 1'b1;
            drv(1, ins[i], 1, 0, 0, 0);
            #1;
            checks++;
            if ({bus.if_ready, bus.rd_a_sel, bus.rd_b_sel} !== {1'b1, ins[i][8:6], ins[i][5:3]}) begin
                failures++; $display("FAIL stream_ready[%0d] got=%h exp=%h", i,
                                     {bus.if_ready, bus.rd_a_sel, bus.rd_b_sel}, {1'b1, ins[i][8:6], ins[i][5:3]});
            end
            if (i > 0) begin
                e = sb.pop_front(); checks++;
                if (got() !== {1'b1, e}) begin
                    failures++; $display("FAIL stream_ex[%0d] got=%h exp=%h", i, got(), {1'b1, e});
                end
            end
            sb.push_back(ex(ins[i]));
        end
        @(negedge clk); drv(0, 16'h0, 1, 0, 0, 0); #1;
        e = sb.pop_front(); checks++;
        if (got() !== {1'b1, e}) begin
            failures++; $display("FAIL stream_last got=%h exp=%h", got(), {1'b1, e});
        end
        @(negedge clk); #1;
        checks++;
        if (got() !== {1'b0, e}) begin
            failures++; $display("FAIL stream_drain got=%h exp=%h", got(), {1'b0, e});
        end
    endtask

    task automatic test_stall;
        logic [15:0] a, b;
        a = mk(4'h1, 3'd6, 3'd3, 3'd5, 3'd2);
        b = mk(4'h2, 3'd7, 3'd7, 3'd1, 3'd3);
        @(negedge clk); drv(1, a, 0, 0, 0, 0); #1;
        checks++;
        if (bus.if_ready !== 1'b1) begin
            failures++; $display("FAIL stall_accept got=%b exp=1", bus.if_ready);
        end
        sb.push_back(ex(a));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); drv(1, b, 0, 0, 0, 0); #1;
            checks++;
            if ({bus.if_ready, bus.rd_a_sel, bus.rd_b_sel, got()} !== {1'b0, 3'd3, 3'd5, 1'b1, sb[0]}) begin
                failures++; $display("FAIL stall_hold[%0d] got=%h exp=%h", i,
                                     {bus.if_ready, bus.rd_a_sel, bus.rd_b_sel, got()}, {1'b0, 3'd3, 3'd5, 1'b1, sb[0]});
            end
        end
        @(negedge clk); drv(1, b, 1, 0, 0, 0); #1;
        e = sb.pop_front(); checks++;
        if ({bus.if_ready, bus.rd_a_sel, got()} !== {1'b1, 3'd7, 1'b1, e}) begin
            failures++; $display("FAIL stall_release got=%h exp=%h", {bus.if_ready, bus.rd_a_sel, got()}, {1'b1, 3'd7, 1'b1, e});
        end
        sb.push_back(ex(b));
        @(negedge clk); drv(0, 16'h0, 1, 0, 0, 0); #1;
        e = sb.pop_front(); checks++;
        if (got() !== {1'b1, e}) begin
            failures++; $display("FAIL stall_next got=%h exp=%h", got(), {1'b1, e});
        end
        @(negedge clk); #1;
    endtask

    task automatic test_flush;
        logic [15:0] a, b;
        a = mk(4'h3, 3'd1, 3'd0, 3'd0, 3'd1);
        b = mk(4'h4, 3'd2, 3'd0, 3'd0, 3'd5);
        @(negedge clk); drv(1, a, 0, 0, 0, 0); #1;
        sb.push_back(ex(a));
        @(negedge clk); drv(1, b, 0, 1, 0, 0); #1;
        checks++;
        if ({bus.if_ready, bus.ex_valid} !== 2'b01) begin
            failures++; $display("FAIL flush_ready got=%b exp=01", {bus.if_ready, bus.ex_valid});
        end
        @(negedge clk); drv(0, b, 1, 0, 0, 0); #1;
        e = sb.pop_front(); checks++;
        if (got() !== {1'b0, e}) begin
            failures++; $display("FAIL flush_kill got=%h exp=%h", got(), {1'b0, e});
        end
    endtask

    task automatic test_reset_midstall;
        logic [15:0] l, u;
        l = mk(4'hA, 3'd6, 3'd0, 3'd0, 3'd0);
        u = mk(4'h1, 3'd0, 3'd6, 3'd0, 3'd0);
        @(negedge clk); drv(1, l, 0, 0, 0, 0); #1;
        @(negedge clk); drv(1, u, 0, 0, 0, 0); #1;
        checks++;
        if ({bus.if_ready, bus.ex_valid} !== 2'b01) begin
            failures++; $display("FAIL midstall_pre got=%b exp=01", {bus.if_ready, bus.ex_valid});
        end
        @(negedge clk); rst_n = 1'b0; #1;
        sb.delete();
        checks++;
        if ({bus.if_ready, got()} !== {1'b1, 1'b0, 4'hF, 3'd0, 3'd0, 1'b0}) begin
            failures++; $display("FAIL midstall_reset got=%h exp=%h", {bus.if_ready, got()}, {1'b1, 1'b0, 4'hF, 3'd0, 3'd0, 1'b0});
        end
        @(negedge clk); rst_n = 1'b1; drv(1, u, 1, 0, 0, 0); #1;
        checks++;
        if (bus.if_ready !== 1'b1) begin
            failures++; $display("FAIL midstall_first got=%b exp=1", bus.if_ready);
        end
        sb.push_back(ex(u));
        @(negedge clk); drv(0, 16'h0, 1, 0, 0, 0); #1;
        e = sb.pop_front(); checks++;
        if (got() !== {1'b1, e}) begin
            failures++; $display("FAIL midstall_issue got=%h exp=%h", got(), {1'b1, e});
        end
        @(negedge clk); #1;
    endtask

`ifdef ID_SCOREBOARD_EN
    task automatic test_load_use;
        logic [15:0] l, u, q [3];
        l = mk(4'hA, 3'd2, 3'd0, 3'd0, 3'd0);
        u = mk(4'h1, 3'd3, 3'd2, 3'd1, 3'd4);
        q[0] = u; q[1] = mk(4'h1, 3'd2, 3'd0, 3'd0, 3'd0); q[2] = mk(4'h1, 3'd0, 3'd0, 3'd2, 3'd0);
        @(negedge clk); drv(1, l, 1, 0, 0, 0); #1;
        sb.push_back(ex(l));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); drv(1, q[i], 1, 0, 0, 0); #1;
            checks++;
            if (bus.if_ready !== 1'b0) begin
                failures++; $display("FAIL loaduse_stall[%0d] got=%b exp=0", i, bus.if_ready);
            end
            if (i == 0) begin
                e = sb.pop_front(); checks++;
                if (got() !== {1'b1, e}) begin
                    failures++; $display("FAIL loaduse_load got=%h exp=%h", got(), {1'b1, e});
                end
            end
        end
        @(negedge clk); drv(1, u, 1, 0, 1, 3'd2); #1;
        checks++;
        if (bus.if_ready !== 1'b0) begin
            failures++; $display("FAIL loaduse_clear_cycle got=%b exp=0", bus.if_ready);
        end
        @(negedge clk); drv(1, u, 1, 0, 0, 0); #1;
        checks++;
        if (bus.if_ready !== 1'b1) begin
            failures++; $display("FAIL loaduse_issue got=%b exp=1", bus.if_ready);
        end
        sb.push_back(ex(u));
        @(negedge clk); drv(0, 16'h0, 1, 0, 0, 0); #1;
        e = sb.pop_front(); checks++;
        if (got() !== {1'b1, e}) begin
            failures++; $display("FAIL loaduse_ex got=%h exp=%h", got(), {1'b1, e});
        end
        @(negedge clk); #1;
    endtask

    task automatic test_set_wins_flush;
        logic [15:0] l, u;
        l = mk(4'hA, 3'd4, 3'd0, 3'd0, 3'd0);
        u = mk(4'h1, 3'd5, 3'd4, 3'd0, 3'd0);
        @(negedge clk); drv(1, l, 1, 0, 1, 3'd4); #1;
        sb.push_back(ex(l));
        @(negedge clk); drv(1, u, 1, 0, 0, 0); #1;
        checks++;
        if (bus.if_ready !== 1'b0) begin
            failures++; $display("FAIL setwins_stall got=%b exp=0", bus.if_ready);
        end
        e = sb.pop_front(); checks++;
        if (got() !== {1'b1, e}) begin
            failures++; $display("FAIL setwins_load got=%h exp=%h", got(), {1'b1, e});
        end
        @(negedge clk); drv(1, u, 1, 1, 0, 0); #1;
        @(negedge clk); drv(1, u, 1, 0, 0, 0); #1;
        checks++;
        if (bus.if_ready !== 1'b0) begin
            failures++; $display("FAIL flush_keeps_pending got=%b exp=0", bus.if_ready);
        end
        @(negedge clk); drv(1, u, 1, 0, 1, 3'd4); #1;
        @(negedge clk); drv(1, u, 1, 0, 0, 0); #1;
        checks++;
        if (bus.if_ready !== 1'b1) begin
            failures++; $display("FAIL setwins_issue got=%b exp=1", bus.if_ready);
        end
        sb.push_back(ex(u));
        @(negedge clk); drv(0, 16'h0, 1, 0, 0, 0); #1;
        e = sb.pop_front(); checks++;
        if (got() !== {1'b1, e}) begin
            failures++; $display("FAIL setwins_ex got=%h exp=%h", got(), {1'b1, e});
        end
        @(negedge clk); #1;
    endtask
`else
    task automatic test_no_scoreboard;
        logic [15:0] l, u;
        l = mk(4'hA, 3'd2, 3'd0, 3'd0, 3'd1);
        u = mk(4'h1, 3'd3, 3'd2, 3'd2, 3'd0);
        @(negedge clk); drv(1, l, 1, 0, 0, 0); #1;
        sb.push_back(ex(l));
        @(negedge clk); drv(1, u, 1, 0, 1, 3'd5); #1;
        checks++;
        if (bus.if_ready !== 1'b1) begin
            failures++; $display("FAIL noscb_issue got=%b exp=1", bus.if_ready);
        end
        e = sb.pop_front(); checks++;
        if (got() !== {1'b1, e}) begin
            failures++; $display("FAIL noscb_load got=%h exp=%h", got(), {1'b1, e});
        end
        sb.push_back(ex(u));
        @(negedge clk); drv(0, 16'h0, 1, 0, 0, 0); #1;
        e = sb.pop_front(); checks++;
        if (got() !== {1'b1, e}) begin
            failures++; $display("FAIL noscb_use got=%h exp=%h", got(), {1'b1, e});
        end
        @(negedge clk); #1;
    endtask
`endif

    initial begin
        test_reset;
        test_alu_stream;
        test_stall;
        test_flush;
`ifdef ID_SCOREBOARD_EN
        test_load_use;
        test_set_wins_flush;
`else
        test_no_scoreboard;
`endif
        test_reset_midstall;
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
